// File: rtl/ifetch_unit_pkg.sv
// Shared LC-3b types for the fetch stage: word type, fetch FSM states, PC step.
package ifetch_unit_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {IDLE, REQ, LOAD} fetch_state_t;

  localparam lc3b_word PC_INC        = 16'd2;
  localparam lc3b_word PC_ALIGN_MASK = 16'hFFFE;

  function automatic lc3b_word align_pc(input lc3b_word addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory read port: request/address out, response strobe/data back.
interface ifetch_unit_if;
  import ifetch_unit_pkg::*;

  lc3b_word mem_address;
  logic     mem_read;
  lc3b_word mem_rdata;
  logic     mem_resp;

  modport master (output mem_address, output mem_read, input mem_rdata, input mem_resp);
  modport slave  (input mem_address, input mem_read, output mem_rdata, output mem_resp);

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Saturating cycle counter for an outstanding fetch; flags the last allowed wait cycle.
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // Keep at least one bit so a disabled timeout still elaborates cleanly.
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (TIMEOUT_CYC != 0) && enable && (count == LAST);

endmodule

// File: rtl/ifetch_unit.sv
// LC-3b instruction fetch: holds PC, reads one word per request, pulses it into IR.
//
//  state | meaning
//  IDLE  | no request outstanding; waits for fetch_en
//  REQ   | mem_read held at pc until mem_resp or timeout
//  LOAD  | ir_load pulse, fetched word presented on ir_data
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter lc3b_word RESET_PC    = 16'h0000,
  parameter int       TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_en,
  input  logic                 redirect,
  input  lc3b_word             redirect_pc,
  ifetch_unit_if.master        mem,
  output lc3b_word             ir_data,
  output logic                 ir_load,
  output lc3b_word             pc,
  output logic                 fetch_err
);

  fetch_state_t state, state_next;
  logic         squash;
  logic         mem_read_c;
  logic         capture;
  logic         pc_inc;
  logic         squash_set;
  logic         squash_clr;
  logic         timeout_hit;
  logic         expire;

  fetch_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != REQ),
    .enable (state == REQ),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    mem_read_c  = 1'b0;
    ir_load     = 1'b0;
    capture     = 1'b0;
    pc_inc      = 1'b0;
    squash_set  = 1'b0;
    squash_clr  = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetch_en) state_next = REQ;
      end
      REQ: begin
        mem_read_c = 1'b1;
        if (mem.mem_resp) begin
          // A redirect arriving with the response kills it just like a pending squash.
          if (squash || redirect) begin
            squash_clr = 1'b1;
            state_next = IDLE;
          end else begin
            capture    = 1'b1;
            pc_inc     = 1'b1;
            state_next = LOAD;
          end
        end else if (expire) begin
          // Abandoned read: any pending squash has nothing left to discard.
          timeout_hit = 1'b1;
          squash_clr  = 1'b1;
          state_next  = IDLE;
        end else if (redirect) begin
          squash_set = 1'b1;
        end
      end
      LOAD: begin
        ir_load    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= align_pc(RESET_PC);
      ir_data   <= '0;
      squash    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= timeout_hit;
      if (redirect) begin
        pc <= align_pc(redirect_pc);
      end else if (pc_inc) begin
        pc <= pc + PC_INC;
      end
      if (capture) begin
        ir_data <= mem.mem_rdata;
      end
      if (squash_clr) begin
        squash <= 1'b0;
      end else if (squash_set) begin
        squash <= 1'b1;
      end
    end
  end

  assign mem.mem_read    = mem_read_c;
  assign mem.mem_address = pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: stimulus predicts deliveries/timeouts, monitor checks them.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam int T = 4;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     fetch_en = 1'b0;
  logic     redirect = 1'b0;
  lc3b_word redirect_pc = '0;
  lc3b_word ir_data;
  logic     ir_load;
  lc3b_word pc;
  logic     fetch_err;

  ifetch_unit_if mem_bus();

  ifetch_unit #(
    .RESET_PC    (16'h0000),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem         (mem_bus),
    .ir_data     (ir_data),
    .ir_load     (ir_load),
    .pc          (pc),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_err;
    lc3b_word data;
    lc3b_word pc;
  } exp_t;

  exp_t     exp_q[$];
  lc3b_word addr_q[$];
  int       total = 0;
  int       bad = 0;
  lc3b_word model_pc = '0;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_evt(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen but none expected", name);
  endfunction

  // Monitor: samples on the falling edge, pops the scoreboard on every DUT event.
  logic     prev_rd = 1'b0;
  logic     prev_resp = 1'b0;
  exp_t     mon_e;
  lc3b_word mon_a;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_bus.mem_read && !prev_rd) begin
        if (addr_q.size() == 0) fail_evt("unexpected_req");
        else begin
          mon_a = addr_q.pop_front();
          chk("mem_address", mem_bus.mem_address, mon_a);
        end
      end
      if (prev_resp) chk("read_gap", 16'(mem_bus.mem_read), 16'd0);
      if (ir_load) begin
        if (exp_q.size() == 0) fail_evt("unexpected_ir_load");
        else begin
          mon_e = exp_q.pop_front();
          chk("load_kind", 16'(mon_e.is_err), 16'd0);
          chk("ir_data", ir_data, mon_e.data);
          chk("pc_at_load", pc, mon_e.pc);
        end
      end
      if (fetch_err) begin
        if (exp_q.size() == 0) fail_evt("unexpected_fetch_err");
        else begin
          mon_e = exp_q.pop_front();
          chk("err_kind", 16'(mon_e.is_err), 16'd1);
          chk("pc_at_err", pc, mon_e.pc);
          chk("err_read_low", 16'(mem_bus.mem_read), 16'd0);
        end
      end
    end
    prev_rd   = mem_bus.mem_read;
    prev_resp = mem_bus.mem_read && mem_bus.mem_resp;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    redirect = 1'b0;
    mem_bus.mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_pc = 16'h0000;
  endtask

  task automatic idle_redirect(input lc3b_word rpc);
    redirect = 1'b1;
    redirect_pc = rpc;
    tick();
    redirect = 1'b0;
    model_pc = rpc & 16'hFFFE;
  endtask

  // lat: REQ cycle (1-based) carrying mem_resp; >T means memory never answers.
  // redir: 0 none, k>=1 redirect in REQ cycle k, -1 redirect during LOAD.
  task automatic fetch_txn(input int lat, input lc3b_word data, input int redir,
                           input lc3b_word rpc, input bit late);
    lc3b_word a;
    exp_t     e;
    a = model_pc;
    addr_q.push_back(a);
    if (lat > T) begin
      e.is_err = 1'b1; e.data = '0; e.pc = a;
      exp_q.push_back(e);
    end else if (redir >= 1) begin
      model_pc = rpc & 16'hFFFE;
    end else begin
      e.is_err = 1'b0; e.data = data; e.pc = a + 16'd2;
      exp_q.push_back(e);
      model_pc = (redir < 0) ? (rpc & 16'hFFFE) : lc3b_word'(a + 16'd2);
    end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int c = 1; c <= T; c++) begin
      mem_bus.mem_resp  = (c == lat);
      mem_bus.mem_rdata = (c == lat) ? data : 16'($urandom);
      redirect = (c == redir);
      redirect_pc = rpc;
      tick();
      mem_bus.mem_resp = 1'b0;
      redirect = 1'b0;
      if (c == lat) break;
    end
    if (lat <= T && redir <= 0) begin
      redirect = (redir < 0);
      redirect_pc = rpc;
      tick();
      redirect = 1'b0;
    end
    if (late) begin
      mem_bus.mem_resp = 1'b1;
      mem_bus.mem_rdata = 16'($urandom);
      tick();
      mem_bus.mem_resp = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int redir;
    int sel;
    mem_bus.mem_resp = 1'b0;
    mem_bus.mem_rdata = '0;

    // Reset values while rst_n is held low.
    @(posedge clk);
    #1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir_data", ir_data, 16'h0000);
    chk("rst_ir_load", 16'(ir_load), 16'd0);
    chk("rst_mem_read", 16'(mem_bus.mem_read), 16'd0);
    chk("rst_fetch_err", 16'(fetch_err), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_pc = 16'h0000;

    // Single fetch with two wait cycles.
    fetch_txn(3, 16'h1A42, 0, 16'h0000, 1'b0);
    chk("t1_pc", pc, 16'h0002);

    // Four back-to-back zero-wait fetches from reset.
    do_reset();
    repeat (4) fetch_txn(1, 16'($urandom), 0, 16'h0000, 1'b0);
    chk("t2_pc", pc, 16'h0008);

    // Redirect while waiting squashes the response.
    fetch_txn(3, 16'hBEEF, 1, 16'h3001, 1'b0);
    chk("t3_pc", pc, 16'h3000);
    fetch_txn(1, 16'($urandom), 0, 16'h0000, 1'b0);

    // Wrap at the top of memory, then redirect during LOAD.
    idle_redirect(16'hFFFF);
    chk("t4_pc_set", pc, 16'hFFFE);
    fetch_txn(2, 16'($urandom), 0, 16'h0000, 1'b0);
    chk("t4_pc_wrap", pc, 16'h0000);
    fetch_txn(1, 16'($urandom), -1, 16'h0400, 1'b0);
    chk("t4_pc_redir", pc, 16'h0400);

    // Timeout with a late response landing in IDLE.
    fetch_txn(9, 16'h0000, 0, 16'h0000, 1'b1);
    chk("t5_pc", pc, 16'h0400);

    // Asynchronous reset in the middle of a request.
    addr_q.push_back(model_pc);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_mem_read", 16'(mem_bus.mem_read), 16'd0);
    chk("t6_pc", pc, 16'h0000);
    chk("t6_ir_data", ir_data, 16'h0000);
    chk("t6_ir_load", 16'(ir_load), 16'd0);
    chk("t6_fetch_err", 16'(fetch_err), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_pc = 16'h0000;
    fetch_txn(1, 16'($urandom), 0, 16'h0000, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) idle_redirect(16'($urandom));
      lat = $urandom_range(1, 6);
      redir = 0;
      if (lat <= T) begin
        sel = $urandom_range(0, 3);
        if (sel == 0) redir = $urandom_range(1, lat);
        else if (sel == 1) redir = -1;
      end
      fetch_txn(lat, 16'($urandom), redir, 16'($urandom),
                (lat > T) ? 1'($urandom_range(0, 1)) : 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    chk("exp_q_drained", 16'(exp_q.size()), 16'd0);
    chk("addr_q_drained", 16'(addr_q.size()), 16'd0);
    chk("final_pc", pc, model_pc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
